// File: rtl/mem_bus_arbiter3.sv
// Three-master arbiter for the shared 16-bit memory bus (fetch, data, DMA).
// The grant is registered, each grant carries one transaction, and a watchdog force-completes a stalled transaction.
module mem_bus_arbiter3 #(
    parameter bit          RR_EN   = 1'b1,
    parameter int          TIMEOUT = 64,
    parameter logic [15:0] TO_DATA = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [18:0] m0_addr,
    input  logic [15:0] m0_data_out,
    input  logic        m0_access,
    input  logic        m0_wr_en,
    input  logic [1:0]  m0_bytesel,
    output logic [15:0] m0_data_in,
    output logic        m0_ack,

    input  logic [18:0] m1_addr,
    input  logic [15:0] m1_data_out,
    input  logic        m1_access,
    input  logic        m1_wr_en,
    input  logic [1:0]  m1_bytesel,
    output logic [15:0] m1_data_in,
    output logic        m1_ack,

    input  logic [18:0] m2_addr,
    input  logic [15:0] m2_data_out,
    input  logic        m2_access,
    input  logic        m2_wr_en,
    input  logic [1:0]  m2_bytesel,
    output logic [15:0] m2_data_in,
    output logic        m2_ack,

    output logic [18:0] s_addr,
    output logic [15:0] s_data_out,
    output logic        s_access,
    output logic        s_wr_en,
    output logic [1:0]  s_bytesel,
    input  logic [15:0] s_data_in,
    input  logic        s_ack,

    output logic        timeout_err
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      grant_id_reg, grant_id_next;
    logic [1:0]      rr_ptr_reg, rr_ptr_next;
    logic [WD_W-1:0] wdog_reg, wdog_next;
    logic            timeout_err_reg, timeout_err_next;

    logic [2:0]      req;
    logic [18:0]     req_addr  [3];
    logic [15:0]     req_wdata [3];
    logic [2:0]      req_wr;
    logic [1:0]      req_bs    [3];

    logic [1:0]      winner_id;
    logic            winner_found;
    logic [1:0]      cand;
    logic            done;
    logic [15:0]     resp_data;
    logic [2:0]      ack_vec;
    logic [15:0]     rdata     [3];

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    assign req          = {m2_access, m1_access, m0_access};
    assign req_wr       = {m2_wr_en, m1_wr_en, m0_wr_en};
    assign req_addr[0]  = m0_addr;
    assign req_addr[1]  = m1_addr;
    assign req_addr[2]  = m2_addr;
    assign req_wdata[0] = m0_data_out;
    assign req_wdata[1] = m1_data_out;
    assign req_wdata[2] = m2_data_out;
    assign req_bs[0]    = m0_bytesel;
    assign req_bs[1]    = m1_bytesel;
    assign req_bs[2]    = m2_bytesel;

    // Round-robin searches upward from the pointer with wrap; fixed mode is M1 > M0 > M2.
    always_comb begin
        winner_id    = 2'd0;
        winner_found = 1'b0;
        cand         = rr_ptr_reg;
        if (RR_EN) begin
            for (int k = 0; k < 3; k++) begin
                if (!winner_found && req[cand]) begin
                    winner_id    = cand;
                    winner_found = 1'b1;
                end
                cand = next_id(cand);
            end
        end else begin
            if (req[1]) begin
                winner_id    = 2'd1;
                winner_found = 1'b1;
            end else if (req[0]) begin
                winner_id    = 2'd0;
                winner_found = 1'b1;
            end else if (req[2]) begin
                winner_id    = 2'd2;
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_id_next    = grant_id_reg;
        rr_ptr_next      = rr_ptr_reg;
        wdog_next        = wdog_reg;
        timeout_err_next = timeout_err_reg;
        done             = 1'b0;
        resp_data        = 16'h0000;
        s_addr           = 19'h00000;
        s_data_out       = 16'h0000;
        s_access         = 1'b0;
        s_wr_en          = 1'b0;
        s_bytesel        = 2'b00;

        case (state_reg)
            IDLE: begin
                if (winner_found) begin
                    state_next    = GRANT;
                    grant_id_next = winner_id;
                    wdog_next     = '0;
                end
            end
            GRANT: begin
                s_addr     = req_addr[grant_id_reg];
                s_data_out = req_wdata[grant_id_reg];
                s_wr_en    = req_wr[grant_id_reg];
                s_bytesel  = req_bs[grant_id_reg];
                s_access   = 1'b1;
                // A real ack wins over a watchdog expiry in the same cycle.
                if (s_ack) begin
                    done      = 1'b1;
                    resp_data = s_data_in;
                end else if (wdog_reg == WD_LAST) begin
                    done             = 1'b1;
                    resp_data        = TO_DATA;
                    s_access         = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
                if (done) begin
                    state_next  = IDLE;
                    rr_ptr_next = next_id(grant_id_reg);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_resp
            assign ack_vec[gi] = done && (grant_id_reg == 2'(gi));
            assign rdata[gi]   = ack_vec[gi] ? resp_data : 16'h0000;
        end
    endgenerate

    assign m0_ack      = ack_vec[0];
    assign m1_ack      = ack_vec[1];
    assign m2_ack      = ack_vec[2];
    assign m0_data_in  = rdata[0];
    assign m1_data_in  = rdata[1];
    assign m2_data_in  = rdata[2];
    assign timeout_err = timeout_err_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg       <= IDLE;
            grant_id_reg    <= 2'd0;
            rr_ptr_reg      <= 2'd0;
            wdog_reg        <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_id_reg    <= grant_id_next;
            rr_ptr_reg      <= rr_ptr_next;
            wdog_reg        <= wdog_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter3.sv
// Bench for mem_bus_arbiter3: directed scenarios plus a randomized run against a transaction-level model.
// Instance a is round-robin, instance b is fixed priority; both use a watchdog of 8 cycles.
module tb_mem_bus_arbiter3;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [18:0] m_addr  [3];
    logic [15:0] m_wdata [3];
    logic [1:0]  m_bs    [3];
    logic [2:0]  m_acc;
    logic [2:0]  m_wr;

    logic        s_ack, s_ack_b;
    logic [15:0] s_rdata, s_rdata_b;

    logic [15:0] a_rdata [3];
    logic [2:0]  a_ack;
    logic [18:0] a_s_addr;
    logic [15:0] a_s_dout;
    logic        a_s_acc, a_s_wr, a_terr;
    logic [1:0]  a_s_bs;

    logic [15:0] b_rdata [3];
    logic [2:0]  b_ack;
    logic [18:0] b_s_addr;
    logic [15:0] b_s_dout;
    logic        b_s_acc, b_s_wr, b_terr;
    logic [1:0]  b_s_bs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter3 #(.RR_EN(1'b1), .TIMEOUT(TO), .TO_DATA(16'hFFFF)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m_addr[0]), .m0_data_out(m_wdata[0]), .m0_access(m_acc[0]), .m0_wr_en(m_wr[0]),
        .m0_bytesel(m_bs[0]), .m0_data_in(a_rdata[0]), .m0_ack(a_ack[0]),
        .m1_addr(m_addr[1]), .m1_data_out(m_wdata[1]), .m1_access(m_acc[1]), .m1_wr_en(m_wr[1]),
        .m1_bytesel(m_bs[1]), .m1_data_in(a_rdata[1]), .m1_ack(a_ack[1]),
        .m2_addr(m_addr[2]), .m2_data_out(m_wdata[2]), .m2_access(m_acc[2]), .m2_wr_en(m_wr[2]),
        .m2_bytesel(m_bs[2]), .m2_data_in(a_rdata[2]), .m2_ack(a_ack[2]),
        .s_addr(a_s_addr), .s_data_out(a_s_dout), .s_access(a_s_acc), .s_wr_en(a_s_wr),
        .s_bytesel(a_s_bs), .s_data_in(s_rdata), .s_ack(s_ack), .timeout_err(a_terr)
    );

    mem_bus_arbiter3 #(.RR_EN(1'b0), .TIMEOUT(TO), .TO_DATA(16'hFFFF)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .m0_addr(m_addr[0]), .m0_data_out(m_wdata[0]), .m0_access(m_acc[0]), .m0_wr_en(m_wr[0]),
        .m0_bytesel(m_bs[0]), .m0_data_in(b_rdata[0]), .m0_ack(b_ack[0]),
        .m1_addr(m_addr[1]), .m1_data_out(m_wdata[1]), .m1_access(m_acc[1]), .m1_wr_en(m_wr[1]),
        .m1_bytesel(m_bs[1]), .m1_data_in(b_rdata[1]), .m1_ack(b_ack[1]),
        .m2_addr(m_addr[2]), .m2_data_out(m_wdata[2]), .m2_access(m_acc[2]), .m2_wr_en(m_wr[2]),
        .m2_bytesel(m_bs[2]), .m2_data_in(b_rdata[2]), .m2_ack(b_ack[2]),
        .s_addr(b_s_addr), .s_data_out(b_s_dout), .s_access(b_s_acc), .s_wr_en(b_s_wr),
        .s_bytesel(b_s_bs), .s_data_in(s_rdata_b), .s_ack(s_ack_b), .timeout_err(b_terr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 3; i++) begin
            m_addr[i]  = 19'h0;
            m_wdata[i] = 16'h0;
            m_bs[i]    = 2'b00;
        end
        m_acc     = 3'b000;
        m_wr      = 3'b000;
        s_ack     = 1'b0;
        s_ack_b   = 1'b0;
        s_rdata   = 16'h0;
        s_rdata_b = 16'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) m_addr[i] = 19'(32'h111 * (i + 1));
        m_acc = 3'b111;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (a_ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", a_ack); end
            checks++;
            if (a_s_acc !== 1'b0) begin errors++; $display("FAIL reset_s_access got %b want 0", a_s_acc); end
            checks++;
            if (a_terr !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b want 0", a_terr); end
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (a_s_acc !== 1'b1 || a_s_addr !== m_addr[0]) begin
            errors++; $display("FAIL reset_first_grant got acc=%b addr=%h want acc=1 addr=%h", a_s_acc, a_s_addr, m_addr[0]);
        end
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        do_reset();
        m_acc[1]  = 1'b1;
        m_addr[1] = 19'h00100;
        step();
        checks++;
        if (a_s_acc !== 1'b1 || a_s_addr !== 19'h00100 || a_ack !== 3'b000) begin
            errors++; $display("FAIL read_grant got acc=%b addr=%h ack=%b want 1 00100 000", a_s_acc, a_s_addr, a_ack);
        end
        s_ack   = 1'b1;
        s_rdata = 16'hBEEF;
        #1;
        checks++;
        if (a_ack !== 3'b010 || a_rdata[1] !== 16'hBEEF) begin
            errors++; $display("FAIL read_ack got ack=%b data=%h want 010 beef", a_ack, a_rdata[1]);
        end
        checks++;
        if (a_rdata[0] !== 16'h0 || a_rdata[2] !== 16'h0) begin
            errors++; $display("FAIL read_other_data got %h %h want 0 0", a_rdata[0], a_rdata[2]);
        end
        step();
        s_ack = 1'b0;
        m_acc = 3'b000;
        #1;
        checks++;
        if (a_ack !== 3'b000 || a_s_acc !== 1'b0 || a_rdata[1] !== 16'h0) begin
            errors++; $display("FAIL read_idle got ack=%b acc=%b data=%h want 000 0 0", a_ack, a_s_acc, a_rdata[1]);
        end
        $display("test_single_read done");
    endtask

    task automatic test_rr_fairness();
        logic [2:0] exp;
        int acks6;
        do_reset();
        m_acc   = 3'b111;
        s_ack   = 1'b1;
        s_rdata = 16'hC0DE;
        acks6   = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp = (c % 2 == 1) ? 3'(1 << (((c - 1) / 2) % 3)) : 3'b000;
            if (c <= 6) acks6 += $countones(a_ack);
            checks++;
            if (a_ack !== exp) begin errors++; $display("FAIL rr_order cycle %0d got %b want %b", c, a_ack, exp); end
        end
        checks++;
        if (acks6 != 3) begin errors++; $display("FAIL rr_rate got %0d acks want 3", acks6); end
        $display("test_rr_fairness done");
    endtask

    task automatic test_fixed_priority();
        int cnt [3];
        do_reset();
        m_acc     = 3'b111;
        s_ack_b   = 1'b1;
        s_rdata_b = 16'h7777;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int i = 0; i < 3; i++) cnt[i] += int'(b_ack[i]);
        end
        checks++;
        if (cnt[0] != 0 || cnt[1] != 3 || cnt[2] != 0) begin
            errors++; $display("FAIL fp_m1_only got %0d/%0d/%0d want 0/3/0", cnt[0], cnt[1], cnt[2]);
        end
        m_acc = 3'b101;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int i = 0; i < 3; i++) cnt[i] += int'(b_ack[i]);
        end
        checks++;
        if (cnt[0] != 3 || cnt[1] != 0 || cnt[2] != 0) begin
            errors++; $display("FAIL fp_m0_next got %0d/%0d/%0d want 3/0/0", cnt[0], cnt[1], cnt[2]);
        end
        $display("test_fixed_priority done");
    endtask

    task automatic test_write_bytesel();
        do_reset();
        m_acc[2]   = 1'b1;
        m_wr[2]    = 1'b1;
        m_wdata[2] = 16'h1234;
        m_bs[2]    = 2'b10;
        m_addr[2]  = 19'($urandom);
        step();
        checks++;
        if (a_s_wr !== 1'b1 || a_s_bs !== 2'b10 || a_s_dout !== 16'h1234 || a_s_addr !== m_addr[2]) begin
            errors++; $display("FAIL wr_grant got wr=%b bs=%b dout=%h addr=%h want 1 10 1234 %h", a_s_wr, a_s_bs, a_s_dout, a_s_addr, m_addr[2]);
        end
        s_ack = 1'b1;
        #1;
        checks++;
        if (a_ack !== 3'b100) begin errors++; $display("FAIL wr_ack got %b want 100", a_ack); end
        step();
        s_ack = 1'b0;
        m_acc = 3'b000;
        #1;
        checks++;
        if (a_s_wr !== 1'b0 || a_s_bs !== 2'b00 || a_s_dout !== 16'h0) begin
            errors++; $display("FAIL wr_idle got wr=%b bs=%b dout=%h want 0 00 0000", a_s_wr, a_s_bs, a_s_dout);
        end
        $display("test_write_bytesel done");
    endtask

    task automatic test_watchdog();
        do_reset();
        m_acc[0]  = 1'b1;
        m_addr[0] = 19'h0ABCD;
        for (int c = 1; c <= TO; c++) begin
            step();
            checks++;
            if (a_ack !== ((c == TO) ? 3'b001 : 3'b000) || a_s_acc !== (c != TO) || a_terr !== 1'b0) begin
                errors++; $display("FAIL wd_cycle %0d got ack=%b acc=%b err=%b", c, a_ack, a_s_acc, a_terr);
            end
        end
        checks++;
        if (a_rdata[0] !== 16'hFFFF) begin errors++; $display("FAIL wd_data got %h want ffff", a_rdata[0]); end
        step();
        m_acc     = 3'b010;
        m_addr[1] = 19'h00042;
        #1;
        checks++;
        if (a_terr !== 1'b1 || a_ack !== 3'b000) begin
            errors++; $display("FAIL wd_sticky got err=%b ack=%b want 1 000", a_terr, a_ack);
        end
        step();
        s_ack   = 1'b1;
        s_rdata = 16'h5A5A;
        #1;
        checks++;
        if (a_ack !== 3'b010 || a_rdata[1] !== 16'h5A5A || a_terr !== 1'b1) begin
            errors++; $display("FAIL wd_next_req got ack=%b data=%h err=%b want 010 5a5a 1", a_ack, a_rdata[1], a_terr);
        end
        step();
        s_ack = 1'b0;
        m_acc = 3'b000;
        #1;
        checks++;
        if (a_terr !== 1'b1) begin errors++; $display("FAIL wd_stays got %b want 1", a_terr); end
        $display("test_watchdog done");
    endtask

    task automatic test_ack_on_timeout();
        do_reset();
        m_acc[2] = 1'b1;
        for (int c = 1; c <= TO; c++) begin
            step();
            if (c == TO) begin
                s_ack   = 1'b1;
                s_rdata = 16'h1357;
                #1;
            end
            checks++;
            if (a_ack !== ((c == TO) ? 3'b100 : 3'b000) || a_s_acc !== 1'b1) begin
                errors++; $display("FAIL edge_cycle %0d got ack=%b acc=%b", c, a_ack, a_s_acc);
            end
        end
        checks++;
        if (a_rdata[2] !== 16'h1357) begin errors++; $display("FAIL edge_data got %h want 1357", a_rdata[2]); end
        step();
        s_ack = 1'b0;
        m_acc = 3'b000;
        #1;
        checks++;
        if (a_terr !== 1'b0) begin errors++; $display("FAIL edge_no_err got %b want 0", a_terr); end
        $display("test_ack_on_timeout done");
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        m_acc[0] = 1'b1;
        step();
        checks++;
        if (a_s_acc !== 1'b1) begin errors++; $display("FAIL mid_grant got acc=%b want 1", a_s_acc); end
        reset_n = 1'b0;
        step();
        s_ack = 1'b1;
        #1;
        checks++;
        if (a_ack !== 3'b000 || a_s_acc !== 1'b0) begin
            errors++; $display("FAIL mid_reset got ack=%b acc=%b want 000 0", a_ack, a_s_acc);
        end
        reset_n = 1'b1;
        m_acc   = 3'b000;
        step();
        checks++;
        if (a_ack !== 3'b000 || a_s_acc !== 1'b0) begin
            errors++; $display("FAIL spurious_ack got ack=%b acc=%b want 000 0", a_ack, a_s_acc);
        end
        s_ack = 1'b0;
        $display("test_reset_mid_grant done");
    endtask

    // Transaction-level reference: busy flag, owner, cycles spent, pointer and sticky error.
    task automatic test_random();
        bit          busy, merr, done;
        int          owner, spent, lat, ptr, n_done;
        logic [2:0]  exp_ack;
        logic [15:0] exp_data, exp_rd;
        do_reset();
        busy = 0; merr = 0; owner = 0; spent = 0; lat = 0; ptr = 0; n_done = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                if (busy && owner == i) begin
                    if (m_acc[i] && $urandom_range(0, 15) == 0) m_acc[i] = 1'b0;
                end else if (!m_acc[i] && $urandom_range(0, 3) == 0) begin
                    m_acc[i]   = 1'b1;
                    m_addr[i]  = 19'($urandom);
                    m_wdata[i] = 16'($urandom);
                    m_wr[i]    = 1'($urandom);
                    m_bs[i]    = 2'($urandom);
                end
            end
            s_rdata = 16'($urandom);
            s_ack   = busy ? (spent == lat) : ($urandom_range(0, 3) == 0);
            #1;
            done     = busy && (s_ack || spent == TO - 1);
            exp_ack  = done ? 3'(1 << owner) : 3'b000;
            exp_data = s_ack ? s_rdata : 16'hFFFF;
            checks++;
            if (a_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack cycle %0d got %b want %b", cyc, a_ack, exp_ack); end
            for (int i = 0; i < 3; i++) begin
                exp_rd = (done && owner == i) ? exp_data : 16'h0;
                checks++;
                if (a_rdata[i] !== exp_rd) begin errors++; $display("FAIL rnd_data m%0d cycle %0d got %h want %h", i, cyc, a_rdata[i], exp_rd); end
            end
            checks++;
            if (a_s_acc !== (busy && !(done && !s_ack))) begin
                errors++; $display("FAIL rnd_s_access cycle %0d got %b want %b", cyc, a_s_acc, busy && !(done && !s_ack));
            end
            checks++;
            if (a_s_addr !== (busy ? m_addr[owner] : 19'h0) || a_s_dout !== (busy ? m_wdata[owner] : 16'h0) ||
                a_s_wr !== (busy ? m_wr[owner] : 1'b0) || a_s_bs !== (busy ? m_bs[owner] : 2'b00)) begin
                errors++; $display("FAIL rnd_bus cycle %0d got addr=%h dout=%h wr=%b bs=%b owner=%0d busy=%0d", cyc, a_s_addr, a_s_dout, a_s_wr, a_s_bs, owner, busy);
            end
            checks++;
            if (a_terr !== merr) begin errors++; $display("FAIL rnd_timeout_err cycle %0d got %b want %b", cyc, a_terr, merr); end
            if (!busy) begin
                for (int k = 0; k < 3; k++) begin
                    if (!busy && m_acc[(ptr + k) % 3]) begin
                        busy  = 1;
                        owner = (ptr + k) % 3;
                    end
                end
                spent = 0;
                lat   = ($urandom_range(0, 4) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 3);
            end else if (done) begin
                if (!s_ack) merr = 1;
                busy = 0;
                ptr  = (owner + 1) % 3;
                m_acc[owner] = 1'b0;
                n_done++;
            end else begin
                spent++;
            end
        end
        checks++;
        if (n_done < 50) begin errors++; $display("FAIL rnd_progress got %0d transactions want >=50", n_done); end
        $display("test_random done: %0d transactions", n_done);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_rr_fairness();
        test_fixed_priority();
        test_write_bytesel();
        test_watchdog();
        test_ack_on_timeout();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
